control_mc: RTL and testbench
=============================

// Module: control_mc
// PURPOSE
//  Multi-cycle control unit for the RV32I CPU. Successor to the single-cycle ADDI-only decoder.
//  Fetches via an instruction-memory req/ack handshake and latches the word into an IR.
//  Decodes ADDI/ADD/SUB/AND/OR/XOR/LUI/BEQ/BNE and sequences FETCH->DECODE->EXEC->WB.
//  Drives the datapath (regfile, ALU, PC) and counts retired instructions.
// PARAMETERS
//  XLEN      32  datapath width; imm is sign-extended to XLEN
//  ALU_OP_W  3   alu_op width (codes below must fit)
//  CNT_W     32  instret counter width
// PORTS
//  clk          in   1         clock, rising edge
//  rst_n        in   1         asynchronous active-low reset
//  imem_req     out  1         fetch request, held until ack
//  imem_ack     in   1         instruction valid this cycle
//  imem_data    in   32        instruction word, sampled when imem_req&&imem_ack
//  alu_zero     in   1         ALU result==0, valid in EXEC
//  imm          out  XLEN      sign-extended immediate (I/B) or {imm20,12'b0} (U)
//  rs1,rs2,rd   out  5 each    register indices from IR
//  alu_op       out  ALU_OP_W  0 passB,1 add,2 sub,3 and,4 or,5 xor
//  alu_src_imm  out  1         1: ALU B operand = imm; 0: = rs2 data
//  rf_we        out  1         regfile write strobe, one cycle in WB
//  pc_we        out  1         PC update strobe, one cycle in WB
//  pc_sel       out  1         valid with pc_we: 0 PC+4, 1 PC+imm (taken branch)
//  illegal      out  1         sticky: unsupported instruction seen, core halted
//  instret      out  CNT_W     retired-instruction count
// BEHAVIOUR
//  Reset (async, rst_n=0): state=FETCH, IR=0, all decode outputs 0,
//   rf_we=pc_we=pc_sel=illegal=0, instret=0.
//   A reset mid-instruction aborts it: no rf_we/pc_we pulse, no count.
//  imem_req = (state==FETCH). It is high from the first clock after reset release.
//  States:
//   FETCH : wait for imem_ack. On ack, IR<=imem_data and go to DECODE.
//   DECODE: register all decode outputs from IR. Go to EXEC; unsupported opcode/funct -> HALT.
//   EXEC  : outputs stable; ALU evaluates; sample alu_zero into taken flag. Go to WB.
//   WB    : pulse pc_we; pulse rf_we for write instrs with rd!=0; instret++. Go to FETCH.
//   HALT  : illegal=1, no strobes, no req. Left only by reset.
//  Timing: ack in cycle n -> DECODE n+1, EXEC n+2, WB n+3, imem_req high again n+4.
//   CPI = 4 + memory wait cycles.
//  Decode:
//   ADDI  op=0010011 f3=000 -> add, src_imm=1, rf_we
//   ADD   op=0110011 f3=000 f7=0000000 -> add, src_imm=0, rf_we
//   SUB   op=0110011 f3=000 f7=0100000 -> sub
//   AND   op=0110011 f3=111 f7=0 -> and
//   OR    op=0110011 f3=110 f7=0 -> or
//   XOR   op=0110011 f3=100 f7=0 -> xor
//   LUI   op=0110111 -> passB, src_imm=1, imm={instr[31:12],12'b0}, rf_we
//   BEQ   op=1100011 f3=000 -> sub, src_imm=0, no rf_we; pc_sel=alu_zero
//   BNE   op=1100011 f3=001 -> sub, src_imm=0, no rf_we; pc_sel=!alu_zero
//   B-imm = sext({i[31],i[7],i[30:25],i[11:8],1'b0}); I-imm = sext(i[31:20]).
//  rd==x0 on a write instruction: executes normally, rf_we stays 0, still retires.
//  Decode outputs hold their value from DECODE through WB; stable while in FETCH.
//  imem_data ignored when no request is outstanding. instret wraps at 2^CNT_W.
// TESTING
//  1. Reset, ADDI x1,x0,5 (0x00500093), ack 1 cycle later -> imm=5, alu_op=1,
//     src_imm=1, rd=1; rf_we & pc_we high exactly at ack+3; pc_sel=0; instret=1.
//  2. ADDI x2,x0,-1 (0xFFF00113) -> imm=0xFFFFFFFF; then SUB x3,x1,x2 (0x402081B3)
//     -> alu_op=2, src_imm=0, rs1=1, rs2=2, rd=3, rf_we.
//  3. BEQ x1,x1,+8 (0x00108463) with alu_zero=1 in EXEC -> imm=8, pc_sel=1,
//     rf_we=0; same word with alu_zero=0 -> pc_sel=0.
//  4. LUI x5,0x12345 (0x123452B7) -> imm=0x12345000, alu_op=0;
//     ADDI x0,x0,1 (0x00100013) -> rf_we stays 0, instret increments.
//  5. ack delayed 5 cycles -> imem_req held high all 5, IR unchanged until ack;
//     0x00000000 fetched -> HALT, illegal=1, imem_req=0 forever, instret frozen.
//  6. Assert rst_n=0 during EXEC of ADD -> no strobes; after release: FETCH,
//     imem_req=1, illegal=0, instret=0.

Source files
------------

// File: rtl/control_mc.sv
`default_nettype none
// ============================================================================
// Module   : control_mc
// Brief    : Multi-cycle RV32I control unit (FETCH/DECODE/EXEC/WB) with IR,
//            decode registers, branch resolution and retired-instruction count.
// Revision : 1.0 - initial release
// ============================================================================
module control_mc #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [31:0]         imem_data,
    input  logic                alu_zero,
    output logic [XLEN-1:0]     imm,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src_imm,
    output logic                rf_we,
    output logic                pc_we,
    output logic                pc_sel,
    output logic                illegal,
    output logic [CNT_W-1:0]    instret
);

    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam logic [ALU_OP_W-1:0] c_ALU_PASSB = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] c_ALU_ADD   = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] c_ALU_SUB   = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] c_ALU_AND   = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] c_ALU_OR    = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] c_ALU_XOR   = ALU_OP_W'(5);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_ir;
    logic                r_wr;
    logic                r_branch;
    logic                r_bne;
    logic                r_taken;
    logic                w_legal;
    logic                w_wr;
    logic                w_branch;
    logic                w_bne;
    logic                w_src_imm;
    logic [ALU_OP_W-1:0] w_alu_op;
    logic signed [31:0]  w_imm32;
    logic [6:0]          w_opcode;
    logic [2:0]          w_f3;
    logic [6:0]          w_f7;

    assign w_opcode = r_ir[6:0];
    assign w_f3     = r_ir[14:12];
    assign w_f7     = r_ir[31:25];

    // Instruction decode from the IR; anything not matched leaves w_legal low.
    always_comb begin
        w_legal   = 1'b0;
        w_wr      = 1'b0;
        w_branch  = 1'b0;
        w_bne     = 1'b0;
        w_src_imm = 1'b0;
        w_alu_op  = c_ALU_PASSB;
        w_imm32   = '0;
        case (w_opcode)
            c_OP_IMM: begin
                if (w_f3 == 3'b000) begin
                    w_legal   = 1'b1;
                    w_wr      = 1'b1;
                    w_src_imm = 1'b1;
                    w_alu_op  = c_ALU_ADD;
                    w_imm32   = {{20{r_ir[31]}}, r_ir[31:20]};
                end
            end
            c_OP_REG: begin
                if (w_f7 == 7'b0000000) begin
                    w_legal = 1'b1;
                    w_wr    = 1'b1;
                    case (w_f3)
                        3'b000:  w_alu_op = c_ALU_ADD;
                        3'b111:  w_alu_op = c_ALU_AND;
                        3'b110:  w_alu_op = c_ALU_OR;
                        3'b100:  w_alu_op = c_ALU_XOR;
                        default: begin
                            w_legal = 1'b0;
                            w_wr    = 1'b0;
                        end
                    endcase
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_legal  = 1'b1;
                    w_wr     = 1'b1;
                    w_alu_op = c_ALU_SUB;
                end
            end
            c_OP_LUI: begin
                w_legal   = 1'b1;
                w_wr      = 1'b1;
                w_src_imm = 1'b1;
                w_alu_op  = c_ALU_PASSB;
                w_imm32   = {r_ir[31:12], 12'b0};
            end
            c_OP_BRANCH: begin
                if (w_f3 == 3'b000 || w_f3 == 3'b001) begin
                    w_legal  = 1'b1;
                    w_branch = 1'b1;
                    w_bne    = w_f3[0];
                    w_alu_op = c_ALU_SUB;
                    w_imm32  = {{19{r_ir[31]}}, r_ir[31], r_ir[7],
                                r_ir[30:25], r_ir[11:8], 1'b0};
                end
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        imem_req = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) w_next = S_DECODE;
            end
            S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
            S_EXEC:   w_next = S_WB;
            S_WB: begin
                pc_we  = 1'b1;
                rf_we  = r_wr && (rd != 5'd0);
                pc_sel = r_taken;
                w_next = S_FETCH;
            end
            S_HALT:   illegal = 1'b1;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir <= '0;
        end else if (r_state == S_FETCH && imem_ack) begin
            r_ir <= imem_data;
        end
    end

    // Decode outputs change only on the DECODE->EXEC edge, so they hold through WB and FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm         <= '0;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            alu_op      <= '0;
            alu_src_imm <= 1'b0;
            r_wr        <= 1'b0;
            r_branch    <= 1'b0;
            r_bne       <= 1'b0;
        end else if (r_state == S_DECODE && w_legal) begin
            imm         <= XLEN'(w_imm32);
            rs1         <= r_ir[19:15];
            rs2         <= r_ir[24:20];
            rd          <= r_ir[11:7];
            alu_op      <= w_alu_op;
            alu_src_imm <= w_src_imm;
            r_wr        <= w_wr;
            r_branch    <= w_branch;
            r_bne       <= w_bne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken <= 1'b0;
            instret <= '0;
        end else begin
            if (r_state == S_EXEC) begin
                r_taken <= r_branch && (r_bne ? !alu_zero : alu_zero);
            end
            if (r_state == S_WB) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_mc
// Brief    : Scoreboard bench for control_mc; driver queues expected WB state,
//            monitor checks it on every pc_we pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic        alu_zero = 1'b0;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  alu_op;
    logic        alu_src_imm, rf_we, pc_we, pc_sel, illegal;
    logic [31:0] instret;

    control_mc #(.XLEN(32), .ALU_OP_W(3), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_data(imem_data), .alu_zero(alu_zero), .imm(imm), .rs1(rs1),
        .rs2(rs2), .rd(rd), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
        .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .illegal(illegal),
        .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rf_we;
        logic        pc_sel;
        logic [31:0] imm;
        logic        chk_imm;
        logic [2:0]  alu_op;
        logic        src_imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] cnt;
        int          ack_cyc;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] exp_cnt = '0;
    logic [31:0] last_imm = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic exp_t mk(logic w, logic ps, logic [31:0] im, logic ci,
                                logic [2:0] op, logic si, logic [4:0] a,
                                logic [4:0] b, logic [4:0] d);
        exp_t e;
        e.rf_we = w; e.pc_sel = ps; e.imm = im; e.chk_imm = ci; e.alu_op = op;
        e.src_imm = si; e.rs1 = a; e.rs2 = b; e.rd = d; e.cnt = '0; e.ack_cyc = 0;
        return e;
    endfunction

    // Monitor: every WB (pc_we) retires the oldest queued instruction.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rf_we && !pc_we) begin
                n_vec++; n_err++;
                $display("FAIL rf_we_without_pc_we: got 1, expected 0 (cycle %0d)", cyc);
            end
            if (pc_we) begin
                if (q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_retire: got pc_we=1, expected none (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wb_timing", cyc, e.ack_cyc + 3);
                    chk("rf_we", {31'b0, rf_we}, {31'b0, e.rf_we});
                    chk("pc_sel", {31'b0, pc_sel}, {31'b0, e.pc_sel});
                    if (e.chk_imm) chk("imm", imm, e.imm);
                    chk("alu_op", {29'b0, alu_op}, {29'b0, e.alu_op});
                    chk("alu_src_imm", {31'b0, alu_src_imm}, {31'b0, e.src_imm});
                    chk("rs1", {27'b0, rs1}, {27'b0, e.rs1});
                    chk("rs2", {27'b0, rs2}, {27'b0, e.rs2});
                    chk("rd", {27'b0, rd}, {27'b0, e.rd});
                    chk("instret_at_wb", instret, e.cnt);
                end
            end
        end
    end

    task automatic wait_req();
        int t = 0;
        while (!imem_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!imem_req) begin
            n_vec++; n_err++;
            $display("FAIL req_timeout: got imem_req=0, expected 1 within 50 cycles");
        end
    endtask

    task automatic issue(input logic [31:0] w, input logic z, input int dly, input exp_t e);
        wait_req();
        for (int i = 0; i < dly; i++) begin
            chk("req_held", {31'b0, imem_req}, 32'd1);
            chk("imm_stable_in_fetch", imm, last_imm);
            @(negedge clk);
        end
        imem_ack  = 1'b1;
        imem_data = w;
        alu_zero  = z;
        e.ack_cyc = cyc;
        e.cnt     = exp_cnt;
        q.push_back(e);
        exp_cnt   = exp_cnt + 1;
        if (e.chk_imm) last_imm = e.imm;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 32'hDEAD_BEEF;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req", {31'b0, imem_req}, 32'd1);
        chk("reset_pc_we", {31'b0, pc_we}, 32'd0);
        chk("reset_rf_we", {31'b0, rf_we}, 32'd0);
        chk("reset_illegal", {31'b0, illegal}, 32'd0);
        chk("reset_instret", instret, 32'd0);
        chk("reset_imm", imm, 32'd0);
        chk("reset_alu_op", {29'b0, alu_op}, 32'd0);

        issue(32'h00500093, 1'b0, 1, mk(1, 0, 32'd5,        1, 3'd1, 1, 5'd0, 5'd5,  5'd1));
        issue(32'hFFF00113, 1'b0, 0, mk(1, 0, 32'hFFFFFFFF, 1, 3'd1, 1, 5'd0, 5'd31, 5'd2));
        issue(32'h402081B3, 1'b0, 0, mk(1, 0, 32'd0,        0, 3'd2, 0, 5'd1, 5'd2,  5'd3));
        issue(32'h0020F233, 1'b0, 0, mk(1, 0, 32'd0,        0, 3'd3, 0, 5'd1, 5'd2,  5'd4));
        issue(32'h0020E333, 1'b0, 0, mk(1, 0, 32'd0,        0, 3'd4, 0, 5'd1, 5'd2,  5'd6));
        issue(32'h0020C3B3, 1'b0, 0, mk(1, 0, 32'd0,        0, 3'd5, 0, 5'd1, 5'd2,  5'd7));
        issue(32'h00208433, 1'b0, 0, mk(1, 0, 32'd0,        0, 3'd1, 0, 5'd1, 5'd2,  5'd8));
        issue(32'h00108463, 1'b1, 0, mk(0, 1, 32'd8,        1, 3'd2, 0, 5'd1, 5'd1,  5'd8));
        issue(32'h00108463, 1'b0, 0, mk(0, 0, 32'd8,        1, 3'd2, 0, 5'd1, 5'd1,  5'd8));
        issue(32'hFE209EE3, 1'b0, 0, mk(0, 1, 32'hFFFFFFFC, 1, 3'd2, 0, 5'd1, 5'd2,  5'd29));
        issue(32'hFE209EE3, 1'b1, 0, mk(0, 0, 32'hFFFFFFFC, 1, 3'd2, 0, 5'd1, 5'd2,  5'd29));
        issue(32'h123452B7, 1'b0, 0, mk(1, 0, 32'h12345000, 1, 3'd0, 1, 5'd8, 5'd3,  5'd5));
        issue(32'h00100013, 1'b0, 0, mk(0, 0, 32'd1,        1, 3'd1, 1, 5'd0, 5'd1,  5'd0));
        issue(32'h00100013, 1'b0, 5, mk(0, 0, 32'd1,        1, 3'd1, 1, 5'd0, 5'd1,  5'd0));

        // All-zero word is not a supported opcode: core must halt.
        wait_req();
        imem_ack  = 1'b1;
        imem_data = 32'h0000_0000;
        @(negedge clk);
        imem_ack  = 1'b0;
        @(negedge clk);
        chk("halt_illegal", {31'b0, illegal}, 32'd1);
        imem_ack  = 1'b1;
        imem_data = 32'h0050_0093;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_req_low", {31'b0, imem_req}, 32'd0);
            chk("halt_instret_frozen", instret, exp_cnt);
        end
        imem_ack = 1'b0;

        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = '0;
        @(negedge clk);
        chk("rst2_req", {31'b0, imem_req}, 32'd1);
        chk("rst2_illegal", {31'b0, illegal}, 32'd0);
        chk("rst2_instret", instret, 32'd0);

        // Abort an ADD with reset while it sits in EXEC.
        wait_req();
        imem_ack  = 1'b1;
        imem_data = 32'h0020_8433;
        @(negedge clk);
        imem_ack  = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_pc_we", {31'b0, pc_we}, 32'd0);
        chk("abort_rf_we", {31'b0, rf_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_req", {31'b0, imem_req}, 32'd1);
        chk("abort_illegal", {31'b0, illegal}, 32'd0);
        chk("abort_instret", instret, 32'd0);
        chk("abort_rd_cleared", {27'b0, rd}, 32'd0);

        issue(32'h00500093, 1'b0, 0, mk(1, 0, 32'd5, 1, 3'd1, 1, 5'd0, 5'd5, 5'd1));
        wait_req();
        chk("final_instret", instret, 32'd1);
        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
